serial_subtractor64: RTL

- Multi-cycle subtractor: computes diff = a - b, processing CHUNK bits per clock with a ripple borrow between chunks.
- Start/done handshake.
- Low-area companion to the combinational lookahead64 adder in the arithmetic datapath.
- Also serves as the subtract unit for adder/subtractor cross-checks.

---
 rtl/serial_subtractor64.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_subtractor64.sv
// Multi-cycle subtractor: diff = a - b, CHUNK bits per clock with a rippled borrow.
// start is accepted in IDLE or DONE; done pulses for one cycle with the held result.
module serial_subtractor64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [CHUNK:0]   chunk_sub;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // One extra bit on the chunk subtraction catches the borrow into the next chunk.
  always_comb begin
    chunk_sub = {1'b0, a_r[cnt*CHUNK +: CHUNK]} - {1'b0, b_r[cnt*CHUNK +: CHUNK]}
              - {{CHUNK{1'b0}}, brw};
    res_next = res_r;
    res_next[cnt*CHUNK +: CHUNK] = chunk_sub[CHUNK-1:0];
    last = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      res_r      <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            res_r <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_r <= res_next;
          brw   <= chunk_sub[CHUNK];
          if (last) begin
            // Visible results move only here, so they stay stable through the next RUN.
            cnt        <= '0;
            diff       <= res_next;
            borrow_out <= chunk_sub[CHUNK];
            overflow   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (res_next[WIDTH-1] != a_r[WIDTH-1]);
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
